// File: rtl/clock_phase_generator_if.sv
// Signal bundle between the LVDC phase generator and the logic that commands it.
// The slave side is the generator; the master side drives run/step and observes phases.
interface clock_phase_generator_if;
   logic       run;
   logic       step;
   logic       cgpp;
   logic       cgppn;
   logic       cgqp;
   logic       cgqpn;
   logic       cgrp;
   logic       cgrpn;
   logic       bop;
   logic [1:0] phase;
   logic       bit_strobe;
   logic       running;
   logic       step_busy;

   modport master (
      output run, step,
      input  cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn, bop,
      input  phase, bit_strobe, running, step_busy
   );

   modport slave (
      input  run, step,
      output cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn, bop,
      output phase, bit_strobe, running, step_busy
   );
endinterface

// File: rtl/clock_phase_generator.sv
// LVDC phase generator: divides clk into the W/X/Y/Z phases of one bit time,
// with free-run, halt-at-bit-boundary and single-bit stepping.
module clock_phase_generator #(
   parameter int DIV = 2,
   parameter int CW  = 8
) (
   input logic                    clk,
   input logic                    rst,
   clock_phase_generator_if.slave bus
);

   typedef enum logic [2:0] {HALT, PW, PX, PY, PZ} state_t;

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   state_t        state, next_state;
   logic [CW-1:0] prescaler, next_prescaler;
   logic          stepping, next_stepping;
   logic          phase_end;

   logic       r_q, q_q, p_q, bop_q, strobe_q, running_q;
   logic [1:0] phase_q;
   logic       r_d, q_d, p_d, bop_d, strobe_d, running_d;
   logic [1:0] phase_d;

   assign phase_end = (prescaler == LAST);

   // Outputs are registered from the decoded next state so they switch cleanly on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HALT;
         prescaler <= '0;
         stepping  <= 1'b0;
         r_q       <= 1'b1;
         q_q       <= 1'b0;
         p_q       <= 1'b0;
         bop_q     <= 1'b1;
         phase_q   <= 2'd2;
         strobe_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= next_state;
         prescaler <= next_prescaler;
         stepping  <= next_stepping;
         r_q       <= r_d;
         q_q       <= q_d;
         p_q       <= p_d;
         bop_q     <= bop_d;
         phase_q   <= phase_d;
         strobe_q  <= strobe_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      next_state     = state;
      next_prescaler = prescaler;
      next_stepping  = stepping;

      unique case (state)
         HALT: begin
            if (bus.run) begin
               next_state = PZ;
            end else if (bus.step) begin
               next_state    = PZ;
               next_stepping = 1'b1;
            end
         end
         PZ: if (phase_end) next_state = PW;
         PW: if (phase_end) next_state = PX;
         PX: if (phase_end) next_state = PY;
         PY: begin
            if (phase_end) begin
               if (bus.run && !stepping) next_state = PZ;
               else                      next_state = HALT;
            end
         end
         default: next_state = HALT;
      endcase

      if (state == HALT || phase_end) next_prescaler = '0;
      else                            next_prescaler = prescaler + CW'(1);

      // A rising run converts a step bit to free-run, but only on a phase boundary.
      if (next_state == HALT)
         next_stepping = 1'b0;
      else if (state != HALT && phase_end && bus.run)
         next_stepping = 1'b0;
   end

   always_comb begin
      r_d       = 1'b1;
      q_d       = 1'b0;
      p_d       = 1'b0;
      bop_d     = 1'b1;
      phase_d   = 2'd2;
      running_d = (next_state != HALT);
      strobe_d  = (next_state == PW) && (next_prescaler == '0);

      unique case (next_state)
         PW: begin r_d = 1'b0; q_d = 1'b1; bop_d = 1'b0; phase_d = 2'd0; end
         PX: begin r_d = 1'b0; q_d = 1'b0; bop_d = 1'b0; phase_d = 2'd1; end
         PY: begin r_d = 1'b1; q_d = 1'b0; bop_d = 1'b0; phase_d = 2'd2; end
         PZ: begin r_d = 1'b1; q_d = 1'b1; bop_d = 1'b0; phase_d = 2'd3; end
         default: begin r_d = 1'b1; q_d = 1'b0; bop_d = 1'b1; phase_d = 2'd2; end
      endcase
   end

   // Each complement comes from the same flop as its true line, so the pair never agrees.
   assign bus.cgrp       = r_q;
   assign bus.cgrpn      = ~r_q;
   assign bus.cgqp       = q_q;
   assign bus.cgqpn      = ~q_q;
   assign bus.cgpp       = p_q;
   assign bus.cgppn      = ~p_q;
   assign bus.bop        = bop_q;
   assign bus.phase      = phase_q;
   assign bus.bit_strobe = strobe_q;
   assign bus.running    = running_q;
   assign bus.step_busy  = stepping;

endmodule

// File: tb/tb_clock_phase_generator.sv
// Bench for clock_phase_generator: one DIV=2 and one DIV=1 instance, directed
// run/step sequences with per-cycle expected phases queued for a monitor.
module tb_clock_phase_generator;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   clock_phase_generator_if ifa ();
   clock_phase_generator_if ifb ();

   clock_phase_generator #(.DIV(2), .CW(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   clock_phase_generator #(.DIV(1), .CW(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   typedef struct packed {
      logic [2:0] code;
      logic       strobe;
      logic       busy;
   } exp_t;

   localparam logic [2:0] C_W = 3'd0;
   localparam logic [2:0] C_X = 3'd1;
   localparam logic [2:0] C_Y = 3'd2;
   localparam logic [2:0] C_Z = 3'd3;
   localparam logic [2:0] C_H = 3'd4;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;
   int   rst_count = 0;

   always @(posedge rst) rst_count = rst_count + 1;

   function automatic exp_t mk(input logic [2:0] code, input int strobe, input int busy);
      exp_t e;
      e.code   = code;
      e.strobe = 1'(strobe);
      e.busy   = 1'(busy);
      return e;
   endfunction

   // Expected {R,Q,P,bop,phase,bit_strobe,running,step_busy} for one cycle.
   function automatic logic [8:0] exp_vec(input exp_t e);
      logic [8:0] v;
      case (e.code)
         C_W:     v = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, e.strobe, 1'b1, e.busy};
         C_X:     v = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, e.strobe, 1'b1, e.busy};
         C_Y:     v = {1'b1, 1'b0, 1'b0, 1'b0, 2'd2, e.strobe, 1'b1, e.busy};
         C_Z:     v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd3, e.strobe, 1'b1, e.busy};
         default: v = {1'b1, 1'b0, 1'b0, 1'b1, 2'd2, e.strobe, 1'b0, e.busy};
      endcase
      return v;
   endfunction

   function automatic logic [8:0] vec_a();
      return {ifa.cgrp, ifa.cgqp, ifa.cgpp, ifa.bop, ifa.phase,
              ifa.bit_strobe, ifa.running, ifa.step_busy};
   endfunction

   function automatic logic [8:0] vec_b();
      return {ifb.cgrp, ifb.cgqp, ifb.cgpp, ifb.bop, ifb.phase,
              ifb.bit_strobe, ifb.running, ifb.step_busy};
   endfunction

   task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_complements();
      check_output("compl_a", {6'd0, ifa.cgrpn, ifa.cgqpn, ifa.cgppn},
                   {6'd0, ~ifa.cgrp, ~ifa.cgqp, ~ifa.cgpp});
      check_output("compl_b", {6'd0, ifb.cgrpn, ifb.cgqpn, ifb.cgppn},
                   {6'd0, ~ifb.cgrp, ~ifb.cgqp, ~ifb.cgpp});
   endtask

   // One cycle: drive inputs before the next rising edge, queue the outputs expected after it.
   task automatic apply_stimulus(input int sel_b, input int r, input int s,
                                 input logic [2:0] code, input int strobe, input int busy);
      @(negedge clk);
      if (sel_b != 0) begin
         ifb.run  = 1'(r);
         ifb.step = 1'(s);
         qb.push_back(mk(code, strobe, busy));
      end else begin
         ifa.run  = 1'(r);
         ifa.step = 1'(s);
         qa.push_back(mk(code, strobe, busy));
      end
   endtask

   task automatic phases(input int sel_b, input int r, input int s,
                         input logic [2:0] code, input int n, input int busy, input int first);
      for (int i = 0; i < n; i++)
         apply_stimulus(sel_b, r, s, code, (code == C_W && i == 0 && first != 0) ? 1 : 0, busy);
   endtask

   logic [1:0] prev_a, prev_b;
   logic       prev_valid = 1'b0;
   int         last_rst = 0;

   always @(posedge clk) begin
      exp_t e;
      int   ch;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         check_output("seq_a", vec_a(), exp_vec(e));
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         check_output("seq_b", vec_b(), exp_vec(e));
      end
      check_complements();
      if (prev_valid && last_rst == rst_count) begin
         ch = int'(ifa.cgrp != prev_a[1]) + int'(ifa.cgqp != prev_a[0]);
         check_output("gray_a", 9'(ch > 1), 9'd0);
         ch = int'(ifb.cgrp != prev_b[1]) + int'(ifb.cgqp != prev_b[0]);
         check_output("gray_b", 9'(ch > 1), 9'd0);
      end
      prev_a     = {ifa.cgrp, ifa.cgqp};
      prev_b     = {ifb.cgrp, ifb.cgqp};
      prev_valid = !rst;
      last_rst   = rst_count;
   end

   initial begin
      rst      = 1'b1;
      ifa.run  = 1'b0;
      ifa.step = 1'b0;
      ifb.run  = 1'b0;
      ifb.step = 1'b0;
      #1;
      check_output("reset_a", vec_a(), exp_vec(mk(C_H, 0, 0)));
      check_output("reset_b", vec_b(), exp_vec(mk(C_H, 0, 0)));
      check_complements();
      @(negedge clk);
      rst = 1'b0;

      // Free-run two full bits on DIV=2, then drop run during PX of the third.
      for (int b = 0; b < 2; b++) begin
         phases(0, 1, 0, C_Z, 2, 0, 1);
         phases(0, 1, 0, C_W, 2, 0, 1);
         phases(0, 1, 0, C_X, 2, 0, 1);
         phases(0, 1, 0, C_Y, 2, 0, 1);
      end
      phases(0, 1, 0, C_Z, 2, 0, 1);
      phases(0, 1, 0, C_W, 2, 0, 1);
      phases(0, 1, 0, C_X, 1, 0, 1);
      phases(0, 0, 0, C_X, 1, 0, 1);
      phases(0, 0, 0, C_Y, 2, 0, 1);
      phases(0, 0, 0, C_H, 3, 0, 1);

      // Single step; a second pulse mid-bit must be ignored.
      apply_stimulus(0, 0, 1, C_Z, 0, 1);
      phases(0, 0, 0, C_Z, 1, 1, 1);
      phases(0, 0, 0, C_W, 2, 1, 1);
      phases(0, 0, 0, C_X, 1, 1, 1);
      apply_stimulus(0, 0, 1, C_X, 0, 1);
      phases(0, 0, 0, C_Y, 2, 1, 1);
      phases(0, 0, 0, C_H, 3, 0, 1);

      // Step, then run rises mid-PZ: stepping clears at the PW boundary.
      apply_stimulus(0, 0, 1, C_Z, 0, 1);
      apply_stimulus(0, 1, 0, C_Z, 0, 1);
      phases(0, 1, 0, C_W, 2, 0, 1);
      phases(0, 1, 0, C_X, 2, 0, 1);
      phases(0, 1, 0, C_Y, 2, 0, 1);
      phases(0, 1, 0, C_Z, 2, 0, 1);
      phases(0, 0, 0, C_W, 2, 0, 1);
      phases(0, 0, 0, C_X, 2, 0, 1);
      phases(0, 0, 0, C_Y, 2, 0, 1);
      phases(0, 0, 0, C_H, 2, 0, 1);

      // Asynchronous reset in the first cycle of PW, then restart.
      phases(0, 1, 0, C_Z, 2, 0, 1);
      phases(0, 1, 0, C_W, 1, 0, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_output("async_rst_a", vec_a(), exp_vec(mk(C_H, 0, 0)));
      check_complements();
      @(negedge clk);
      rst     = 1'b0;
      ifa.run = 1'b1;
      qa.push_back(mk(C_Z, 0, 0));
      phases(0, 1, 0, C_Z, 1, 0, 1);
      phases(0, 1, 0, C_W, 2, 0, 1);
      phases(0, 0, 0, C_X, 2, 0, 1);
      phases(0, 0, 0, C_Y, 2, 0, 1);
      phases(0, 0, 0, C_H, 2, 0, 1);

      // DIV=1: one clk per phase, strobe every fourth clk.
      for (int b = 0; b < 2; b++) begin
         phases(1, 1, 0, C_Z, 1, 0, 1);
         phases(1, 1, 0, C_W, 1, 0, 1);
         phases(1, 1, 0, C_X, 1, 0, 1);
         phases(1, 1, 0, C_Y, 1, 0, 1);
      end
      phases(1, 1, 0, C_Z, 1, 0, 1);
      phases(1, 0, 0, C_W, 1, 0, 1);
      phases(1, 0, 0, C_X, 1, 0, 1);
      phases(1, 0, 0, C_Y, 1, 0, 1);
      phases(1, 0, 0, C_H, 2, 0, 1);
      apply_stimulus(1, 0, 1, C_Z, 0, 1);
      phases(1, 0, 0, C_W, 1, 1, 1);
      phases(1, 0, 0, C_X, 1, 1, 1);
      phases(1, 0, 0, C_Y, 1, 1, 1);
      phases(1, 0, 0, C_H, 2, 0, 1);

      repeat (3) @(posedge clk);
      #3;
      check_output("drain", 9'(qa.size() + qb.size()), 9'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
